// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: CPU-side word request/response bundle between the memory stage and sram_ctrl.
// Latency: none, wires only.
// Backpressure: the requester holds rd_en/wr_en/address/write_data stable while ready is low.
interface sram_ctrl_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: splits one 32-bit CPU word access into two 16-bit SRAM half-word cycles, low half first.
// Latency: 2*WAIT_CYCLES+3 cycles of ready=0 per word; SRAM_CTRL_POSTED_WRITE_EN releases writes at once.
// Backpressure: ready (combinational) stays low while a word access is in flight; DONE ignores new requests.
module sram_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  sram_ctrl_if.slave  cpu,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0]  LP_WAIT = 3'(WAIT_CYCLES);
  localparam logic [31:0] LP_BASE = 32'(BASE_ADDR);
`ifdef SRAM_CTRL_POSTED_WRITE_EN
  localparam bit LP_POSTED = 1'b1;
`else
  localparam bit LP_POSTED = 1'b0;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic [16:0] r_word;
  logic [31:0] r_wdata;
  logic        r_is_wr;
  logic [31:0] r_rdata;

  logic        w_req;
  logic        w_take;
  logic        w_active;
  logic        w_hi;
  logic        w_phase_end;
  logic [31:0] w_offset;
  logic        w_unused;
  logic        w_dq_oe;
  logic [15:0] w_dq_out;

  assign w_req       = cpu.rd_en | cpu.wr_en;
  assign w_active    = (r_state == S_LOW) || (r_state == S_HIGH);
  assign w_hi        = (r_state == S_HIGH);
  assign w_phase_end = w_active && (r_cnt == LP_WAIT);
  // Modulo-2^32 offset; only word bits [18:2] reach the SRAM, the rest wrap silently.
  assign w_offset    = cpu.address - LP_BASE;
  assign w_unused    = ^{w_offset[31:19], w_offset[1:0]};
  assign cpu.read_data = r_rdata;

  // Next-state logic: each half-word phase lasts WAIT_CYCLES+1 cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_take      = 1'b1;
          w_state_nxt = S_LOW;
          w_cnt_nxt   = 3'd0;
        end
      end
      S_LOW: begin
        if (w_phase_end) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_HIGH: begin
        if (w_phase_end) begin
          // A posted write already released the pipeline, so it skips DONE.
          w_state_nxt = (LP_POSTED && r_is_wr) ? S_IDLE : S_DONE;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Ready: free in IDLE without a request, in DONE, and for a posted write taken in IDLE.
  always_comb begin
    cpu.ready = 1'b0;
    case (r_state)
      S_IDLE:  cpu.ready = !w_req || (LP_POSTED && cpu.wr_en);
      S_DONE:  cpu.ready = 1'b1;
      default: cpu.ready = 1'b0;
    endcase
  end

  // SRAM strobes, half-word address and write data follow the current phase.
  always_comb begin
    SRAM_CE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_ADDR = '0;
    w_dq_oe   = 1'b0;
    w_dq_out  = r_wdata[15:0];
    if (w_active) begin
      SRAM_CE_N = 1'b0;
      SRAM_UB_N = 1'b0;
      SRAM_LB_N = 1'b0;
      SRAM_WE_N = !r_is_wr;
      SRAM_OE_N = r_is_wr;
      SRAM_ADDR = {r_word, w_hi};
      w_dq_oe   = r_is_wr;
      w_dq_out  = w_hi ? r_wdata[31:16] : r_wdata[15:0];
    end
  end

  assign SRAM_DQ = w_dq_oe ? w_dq_out : 16'bz;

  // State register and phase counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Latch the request when it is accepted; a write wins when both requests are high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word  <= '0;
      r_wdata <= '0;
      r_is_wr <= 1'b0;
    end else if (w_take) begin
      r_word  <= w_offset[18:2];
      r_wdata <= cpu.write_data;
      r_is_wr <= cpu.wr_en;
    end
  end

  // Capture each read half on the last cycle of its phase; writes leave read_data alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_phase_end && !r_is_wr) begin
      if (w_hi) begin
        r_rdata[31:16] <= SRAM_DQ;
      end else begin
        r_rdata[15:0] <= SRAM_DQ;
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized word traffic against a word-level reference memory and an SRAM pin model.
// Latency: checks ready timing per cycle against the half-word phase schedule.
// Backpressure: requester holds its request until ready, then drops it.
`timescale 1ns/1ps
module tb_sram_ctrl;

  localparam int          W       = 1;
  localparam logic [31:0] BASE    = 32'd1024;
  localparam int          BLK_LAT = 2 * W + 3;
`ifdef SRAM_CTRL_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_ctrl_if bus ();
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;

  sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (bus),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .SRAM_WE_N (we_n),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n)
  );

  // SRAM pin model; 'probe' drives zeros onto the bus so any DUT drive shows up when it should be Z.
  logic [15:0] sram_mem [0:262143];
  logic        probe = 1'b0;
  assign sram_dq = (!ce_n && !oe_n) ? sram_mem[sram_addr] : (probe ? 16'h0000 : 16'hzzzz);
  always @(posedge clk) begin
    if (!ce_n && !we_n) sram_mem[sram_addr] <= sram_dq;
  end

  // Word-level reference: key is the SRAM word index of the CPU address.
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] last_rd = 32'h0;
  int checks = 0;
  int errors = 0;

  function automatic int unsigned key_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return 32'(off[18:2]);
  endfunction

  // Drives one request from IDLE and observes every cycle of it; returns latency, bus deviations, read data.
  task automatic run_access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                            output int lat, output int bad, output logic [31:0] rdat);
    logic [16:0] key;
    bit          posted_wr;
    int          last_k;
    int          ph;
    logic [15:0] exp_dq;
    key       = 17'(key_of(a));
    posted_wr = POSTED && wr;
    last_k    = posted_wr ? 2 * W + 2 : 2 * W + 3;
    lat = -1; bad = 0; rdat = '0;
    @(negedge clk);
    bus.rd_en = rd; bus.wr_en = wr; bus.address = a; bus.write_data = d;
    for (int k = 0; k < 64; k++) begin
      ph = (k == 0) ? 0 : (k <= W + 1) ? 1 : (k <= 2 * W + 2) ? 2 : 3;
      if (lat >= 0) begin bus.rd_en = 1'b0; bus.wr_en = 1'b0; end
      probe = (ph == 1 || ph == 2) ? 1'b0 : 1'b1;
      #1;
      if (ph == 1 || ph == 2) begin
        if ({ce_n, ub_n, lb_n} !== 3'b000 || we_n !== !wr || oe_n !== wr ||
            sram_addr !== {key, ph == 2}) bad++;
        if (wr) begin
          exp_dq = (ph == 1) ? d[15:0] : d[31:16];
          if (sram_dq !== exp_dq) bad++;
        end
      end else begin
        if ({ce_n, ub_n, lb_n, we_n, oe_n} !== 5'h1f || sram_dq !== 16'h0000) bad++;
      end
      if (bus.ready !== ((posted_wr ? (k == 0) : (k == 2 * W + 3)) ? 1'b1 : 1'b0)) bad++;
      if (bus.ready === 1'b1 && lat < 0) begin lat = k; rdat = bus.read_data; end
      if (lat >= 0 && k >= last_k) break;
      @(negedge clk);
    end
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    probe = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.address = '0; bus.write_data = '0;
    @(negedge clk);
    rst = 1'b0; probe = 1'b1;
    #1;
    checks++; if ({ce_n, ub_n, lb_n, we_n, oe_n} !== 5'h1f) begin errors++;
      $display("FAIL reset_strobes: got %b expected 11111", {ce_n, ub_n, lb_n, we_n, oe_n}); end
    checks++; if (sram_addr !== 18'h0) begin errors++;
      $display("FAIL reset_addr: got %0h expected 0", sram_addr); end
    checks++; if (sram_dq !== 16'h0000) begin errors++;
      $display("FAIL reset_dq_z: bus reads %0h with probe 0", sram_dq); end
    checks++; if (bus.read_data !== 32'h0) begin errors++;
      $display("FAIL reset_read_data: got %0h expected 0", bus.read_data); end
    checks++; if (bus.ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready: got %b expected 1", bus.ready); end
    probe = 1'b0;
  endtask

  task automatic test_write_read();
    int lat, bad; logic [31:0] rdat;
    run_access(1'b1, 1'b0, BASE, 32'hDEADBEEF, lat, bad, rdat);
    ref_mem[key_of(BASE)] = 32'hDEADBEEF;
    checks++; if (lat != (POSTED ? 0 : BLK_LAT)) begin errors++;
      $display("FAIL wr_latency: got %0d expected %0d", lat, POSTED ? 0 : BLK_LAT); end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL wr_bus: %0d bad cycles expected 0", bad); end
    run_access(1'b0, 1'b1, BASE, 32'h0, lat, bad, rdat);
    last_rd = ref_mem[key_of(BASE)];
    checks++; if (lat != BLK_LAT) begin errors++;
      $display("FAIL rd_latency: got %0d expected %0d", lat, BLK_LAT); end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL rd_bus: %0d bad cycles expected 0", bad); end
    checks++; if (rdat !== 32'hDEADBEEF) begin errors++;
      $display("FAIL rd_data: got %0h expected deadbeef", rdat); end
    run_access(1'b1, 1'b0, BASE + 32'd4, 32'h0BADF00D, lat, bad, rdat);
    ref_mem[key_of(BASE + 32'd4)] = 32'h0BADF00D;
    checks++; if (bus.read_data !== last_rd) begin errors++;
      $display("FAIL rd_hold: got %0h expected %0h", bus.read_data, last_rd); end
  endtask

  task automatic test_both_high();
    int lat, bad; logic [31:0] rdat;
    run_access(1'b1, 1'b1, 32'd1036, 32'hA5C3_1E0F, lat, bad, rdat);
    ref_mem[key_of(32'd1036)] = 32'hA5C3_1E0F;
    checks++; if (bad != 0) begin errors++;
      $display("FAIL both_bus: %0d bad cycles (expected write at 6/7)", bad); end
    run_access(1'b0, 1'b1, 32'd1036, 32'h0, lat, bad, rdat);
    last_rd = 32'hA5C3_1E0F;
    checks++; if (rdat !== 32'hA5C3_1E0F) begin errors++;
      $display("FAIL both_readback: got %0h expected a5c31e0f", rdat); end
  endtask

  task automatic test_back_to_back();
    int lat, bad; logic [31:0] rdat, a, d;
    for (int i = 0; i < 2; i++) begin
      a = BASE + 32'(($urandom_range(16, 31)) * 4);
      d = $urandom;
      run_access(1'b1, 1'b0, a, d, lat, bad, rdat);
      ref_mem[key_of(a)] = d;
      run_access(1'b0, 1'b1, a, 32'h0, lat, bad, rdat);
      last_rd = d;
      checks++; if (lat != BLK_LAT || bad != 0) begin errors++;
        $display("FAIL b2b_read_timing: lat %0d bad %0d expected lat %0d bad 0", lat, bad, BLK_LAT); end
      checks++; if (rdat !== d) begin errors++;
        $display("FAIL b2b_read_data: got %0h expected %0h", rdat, d); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int unsigned sel, key;
      logic [31:0] a, d, rdat, exp;
      bit wr, rd;
      int lat, bad, exp_lat;
      sel = $urandom_range(0, 8);
      a = (sel == 8) ? BASE - 32'd4 : BASE + 32'(sel * 4);
      a = a + 32'($urandom_range(0, 3)) + (32'($urandom_range(0, 2)) << 19);
      key = key_of(a);
      wr = !ref_mem.exists(key) || ($urandom_range(0, 1) == 1);
      rd = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
      d = $urandom;
      exp_lat = (wr && POSTED) ? 0 : BLK_LAT;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_access(wr, rd, a, d, lat, bad, rdat);
      checks++; if (lat != exp_lat) begin errors++;
        $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, exp_lat); end
      checks++; if (bad != 0) begin errors++;
        $display("FAIL rnd_bus[%0d]: %0d bad cycles expected 0 (addr %0h)", i, bad, a); end
      if (wr) begin
        ref_mem[key] = d;
        checks++; if (bus.read_data !== last_rd) begin errors++;
          $display("FAIL rnd_hold[%0d]: got %0h expected %0h", i, bus.read_data, last_rd); end
      end else begin
        exp = ref_mem[key];
        last_rd = exp;
        checks++; if (rdat !== exp) begin errors++;
          $display("FAIL rnd_read[%0d]: got %0h expected %0h (addr %0h)", i, rdat, exp, a); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    a = BASE + 32'h200;
    @(negedge clk);
    bus.wr_en = 1'b1; bus.rd_en = 1'b0; bus.address = a; bus.write_data = 32'hCAFE_0001;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.wr_en = 1'b0; probe = 1'b1;
    #1;
    ref_mem.delete(key_of(a));
    checks++; if ({ce_n, we_n} !== 2'b11) begin errors++;
      $display("FAIL midrst_strobes: ce_n/we_n got %b expected 11", {ce_n, we_n}); end
    checks++; if (sram_dq !== 16'h0000) begin errors++;
      $display("FAIL midrst_dq_z: bus reads %0h with probe 0", sram_dq); end
    checks++; if (bus.ready !== 1'b1) begin errors++;
      $display("FAIL midrst_ready: got %b expected 1", bus.ready); end
    checks++; if (bus.read_data !== 32'h0) begin errors++;
      $display("FAIL midrst_read_data: got %0h expected 0", bus.read_data); end
    last_rd = 32'h0;
    probe = 1'b0;
  endtask

  task automatic test_posted();
`ifdef SRAM_CTRL_POSTED_WRITE_EN
    logic [31:0] a;
    int k;
    a = BASE + 32'h40;
    @(negedge clk);
    bus.wr_en = 1'b1; bus.rd_en = 1'b0; bus.address = a; bus.write_data = 32'h12345678;
    #1;
    checks++; if (bus.ready !== 1'b1) begin errors++;
      $display("FAIL posted_ready: got %b expected 1", bus.ready); end
    @(negedge clk);
    bus.wr_en = 1'b0; bus.rd_en = 1'b1;
    #1;
    k = 1;
    while (bus.ready !== 1'b1 && k < 64) begin
      @(negedge clk); #1; k++;
    end
    checks++; if (k != 4 * W + 6) begin errors++;
      $display("FAIL posted_read_cycle: ready at %0d expected %0d", k, 4 * W + 6); end
    checks++; if (bus.read_data !== 32'h12345678) begin errors++;
      $display("FAIL posted_read_data: got %0h expected 12345678", bus.read_data); end
    bus.rd_en = 1'b0;
    ref_mem[key_of(a)] = 32'h12345678;
    last_rd = 32'h12345678;
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_both_high();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_posted();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
